countdown_timer: RTL



---
 rtl/timer_pkg.sv | 12 +
 rtl/countdown_timer.sv | 86 ++++++++
 2 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default counter width.
package timer_pkg;

    localparam int unsigned TIMER_VALUE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } timer_state_t;

endpackage : timer_pkg

// File: rtl/countdown_timer.sv
// Seconds countdown driven by the 1 Hz divider strobe; pulses expired when the interval completes.
// Optional TIMER_PAUSE_EN adds a pause input that freezes the count while in COUNT.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned VALUE_W = TIMER_VALUE_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_timer,
    input  logic [VALUE_W-1:0] value,
    input  logic               one_hz_enable,
`ifdef TIMER_PAUSE_EN
    input  logic               pause,
`endif
    output logic               divider_restart,
    output logic               busy,
    output logic               expired
);

    timer_state_t       state;
    timer_state_t       state_next;
    logic [VALUE_W-1:0] count;
    logic [VALUE_W-1:0] count_next;
    logic               restart_next;
    logic               tick;

`ifdef TIMER_PAUSE_EN
    assign tick = one_hz_enable & ~pause;
`else
    assign tick = one_hz_enable;
`endif

    // A start request takes priority over any tick in the same cycle, in every state.
    always_comb begin
        state_next   = state;
        count_next   = count;
        restart_next = 1'b0;
        if (start_timer) begin
            count_next   = value;
            restart_next = 1'b1;
            state_next   = (value == '0) ? DONE : COUNT;
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                COUNT: begin
                    if (tick) begin
                        if (count <= VALUE_W'(1)) begin
                            count_next = '0;
                            state_next = DONE;
                        end else begin
                            count_next = count - VALUE_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            count           <= '0;
            busy            <= 1'b0;
            expired         <= 1'b0;
            divider_restart <= 1'b0;
        end else begin
            state           <= state_next;
            count           <= count_next;
            busy            <= (state_next == COUNT);
            expired         <= (state_next == DONE);
            divider_restart <= restart_next;
        end
    end

endmodule : countdown_timer
